jump_target_gen: RTL and testbench



---
 rtl/jtg_pkg.sv | 10 +
 rtl/jtg_stage.sv | 31 +++
 rtl/jump_target_gen.sv | 100 ++++++++++
 tb/tb_jump_target_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtg_pkg.sv
// jtg_pkg: shared mode encoding and constants for the jump target generator
package jtg_pkg;
   typedef enum logic [1:0] {
      MODE_SEQ    = 2'b00,
      MODE_JUMP   = 2'b01,
      MODE_BRANCH = 2'b10,
      MODE_JREG   = 2'b11
   } jtg_mode_e;
   localparam int PC_INCR = 4;
endpackage

// File: rtl/jtg_stage.sv
// jtg_stage: one valid/ready pipeline register with flush
module jtg_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         r_valid;
   logic [W-1:0] r_data;
   assign in_ready  = !r_valid || out_ready;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   // data loads only on acceptance so a stalled result stays stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (flush) r_valid <= 1'b0;
         else if (in_ready) r_valid <= in_valid;
         if (in_valid && in_ready && !flush) r_data <= in_data;
      end
   end
endmodule

// File: rtl/jump_target_gen.sv
// jump_target_gen: two-stage next-PC generator; JTG_MISALIGN_CHECK_EN adds out_misalign
module jump_target_gen
   import jtg_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 26,
   parameter int IMM_W   = 16,
   parameter int SHIFT   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_mode,
   input  logic              in_taken,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [INDEX_W-1:0] in_index,
   input  logic [ADDR_W-1:0] in_reg,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_target,
`ifdef JTG_MISALIGN_CHECK_EN
   output logic              out_misalign,
`endif
   output logic              out_redirect
);
   generate
      if (INDEX_W + SHIFT > ADDR_W || IMM_W > INDEX_W) begin : g_bad_params
         $error("jump_target_gen: INDEX_W+SHIFT must fit ADDR_W and IMM_W must fit INDEX_W");
      end
   endgenerate

   localparam int S1_W = 2 * ADDR_W + 3;
`ifdef JTG_MISALIGN_CHECK_EN
   localparam int S2_W = ADDR_W + 2;
   localparam logic [ADDR_W-1:0] SMASK = ~({ADDR_W{1'b1}} << SHIFT);
`else
   localparam int S2_W = ADDR_W + 1;
`endif
   localparam logic [ADDR_W-1:0] JMASK = ~({ADDR_W{1'b1}} << (INDEX_W + SHIFT));

   jtg_mode_e         w_mode, w_s1_mode;
   logic [IMM_W-1:0]  w_imm;
   logic [ADDR_W-1:0] w_pc4, w_boff, w_jidx, w_op, w_target;
   logic [ADDR_W-1:0] w_s1_pc4, w_s1_op;
   logic              w_taken, w_redir, w_s1_redir;
   logic              w_s1_valid, w_s2_ready;
   logic [S1_W-1:0]   w_s1_in, w_s1_q;
   logic [S2_W-1:0]   w_s2_in, w_s2_q;

   // S1 operand: the only per-mode value that needs the raw request fields
   always_comb begin
      w_mode  = jtg_mode_e'(in_mode);
      w_pc4   = in_pc + ADDR_W'(PC_INCR);
      w_imm   = in_index[IMM_W-1:0];
      w_boff  = ADDR_W'($signed(w_imm)) << SHIFT;
      w_jidx  = ADDR_W'(in_index) << SHIFT;
      w_taken = (w_mode == MODE_BRANCH) && in_taken;
      w_op    = (w_mode == MODE_JREG) ? in_reg :
                (w_mode == MODE_JUMP) ? w_jidx :
                w_taken ? w_boff : '0;
      w_redir = (w_mode == MODE_JUMP) || (w_mode == MODE_JREG) || w_taken;
      w_s1_in = {w_redir, in_mode, w_pc4, w_op};
   end

   jtg_stage #(.W(S1_W)) u_s1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_data(w_s1_in), .in_ready(in_ready),
      .out_valid(w_s1_valid), .out_ready(w_s2_ready), .out_data(w_s1_q)
   );

   // S2 target: SEQ and not-taken BRANCH carry a zero operand so pc4+op covers them
   always_comb begin
      w_s1_redir = w_s1_q[S1_W-1];
      w_s1_mode  = jtg_mode_e'(w_s1_q[S1_W-2 -: 2]);
      w_s1_pc4   = w_s1_q[2*ADDR_W-1 -: ADDR_W];
      w_s1_op    = w_s1_q[ADDR_W-1:0];
      w_target   = (w_s1_mode == MODE_JREG) ? w_s1_op :
                   (w_s1_mode == MODE_JUMP) ? ((w_s1_pc4 & ~JMASK) | w_s1_op) :
                   w_s1_pc4 + w_s1_op;
`ifdef JTG_MISALIGN_CHECK_EN
      w_s2_in    = {(w_s1_mode == MODE_JREG) && |(w_s1_op & SMASK), w_s1_redir, w_target};
`else
      w_s2_in    = {w_s1_redir, w_target};
`endif
   end

   jtg_stage #(.W(S2_W)) u_s2 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(w_s1_valid), .in_data(w_s2_in), .in_ready(w_s2_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(w_s2_q)
   );

   assign out_target   = w_s2_q[ADDR_W-1:0];
   assign out_redirect = w_s2_q[ADDR_W];
`ifdef JTG_MISALIGN_CHECK_EN
   assign out_misalign = w_s2_q[ADDR_W+1] && out_valid;
`endif
endmodule

// File: tb/tb_jump_target_gen.sv
// tb_jump_target_gen: randomized and directed checks against a next-PC reference model
module tb_jump_target_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_mode = 2'd0;
   logic        in_taken = 1'b0;
   logic [31:0] in_pc = '0;
   logic [25:0] in_index = '0;
   logic [31:0] in_reg = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_target;
   logic        out_redirect;
`ifdef JTG_MISALIGN_CHECK_EN
   logic        out_misalign;
`endif

   typedef struct {
      logic [31:0] t;
      logic        r;
      logic        m;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   n_pop = 0;

   jump_target_gen dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_taken(in_taken), .in_pc(in_pc), .in_index(in_index),
      .in_reg(in_reg), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_target(out_target),
`ifdef JTG_MISALIGN_CHECK_EN
      .out_misalign(out_misalign),
`endif
      .out_redirect(out_redirect)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] mode, input logic taken,
                                  input logic [31:0] pc, input logic [25:0] idx,
                                  input logic [31:0] rg);
      exp_t        e;
      logic [31:0] pc4, off;
      logic [15:0] imm;
      pc4 = pc + 32'd4;
      imm = idx[15:0];
      off = {{14{imm[15]}}, imm, 2'b00};
      e.m = 1'b0;
      case (mode)
         2'd0: begin e.t = pc4; e.r = 1'b0; end
         2'd1: begin e.t = (pc4 & 32'hF000_0000) | {4'h0, idx, 2'b00}; e.r = 1'b1; end
         2'd2: begin e.t = taken ? pc4 + off : pc4; e.r = taken; end
         default: begin e.t = rg; e.r = 1'b1; e.m = rg[1:0] != 2'b00; end
      endcase
      return e;
   endfunction

   task automatic set_req(input logic [1:0] mode, input logic taken, input logic [31:0] pc,
                          input logic [25:0] idx, input logic [31:0] rg);
      in_mode = mode; in_taken = taken; in_pc = pc; in_index = idx; in_reg = rg;
   endtask

   task automatic set_rand();
      set_req(2'($urandom_range(0, 3)), 1'($urandom), $urandom, 26'($urandom), $urandom);
   endtask

   task automatic cycle(output bit acc);
      bit pop;
      #1;
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (out_valid) begin
         if (q.size() == 0) chk("spurious_valid", out_valid, 1'b0);
         else begin
            chk("target", out_target, q[0].t);
            chk("redirect", out_redirect, q[0].r);
`ifdef JTG_MISALIGN_CHECK_EN
            chk("misalign", out_misalign, q[0].m);
`endif
         end
      end
      pop = out_valid && out_ready && !flush && q.size() > 0;
      acc = in_valid && in_ready && !flush;
      if (flush) q.delete();
      else begin
         if (pop) begin void'(q.pop_front()); n_pop++; end
         if (acc) q.push_back(model(in_mode, in_taken, in_pc, in_index, in_reg));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bit          acc;
      int          k, base;
      logic [31:0] pcs[3];
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_target", out_target, 32'h0);
      chk("rst_redirect", out_redirect, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      out_ready = 1'b1;
      set_req(2'd1, 1'b0, 32'h0040_0000, 26'h010_0000, 32'h0);
      in_valid = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      chk("jump_lat1", out_valid, 1'b0);
      cycle(acc);
      chk("jump_lat2", out_valid, 1'b1);
      chk("jump_target", out_target, 32'h0040_0000);
      chk("jump_redirect", out_redirect, 1'b1);
      cycle(acc);

      in_valid = 1'b1;
      set_req(2'd2, 1'b1, 32'h0040_0010, 26'h000_FFFF, 32'h0);
      cycle(acc);
      set_req(2'd2, 1'b0, 32'h0040_0010, 26'h000_FFFF, 32'h0);
      cycle(acc);
      in_valid = 1'b0;
      chk("br_taken_target", out_target, 32'h0040_0010);
      chk("br_taken_redirect", out_redirect, 1'b1);
      cycle(acc);
      chk("br_nt_target", out_target, 32'h0040_0014);
      chk("br_nt_redirect", out_redirect, 1'b0);
      cycle(acc);

      in_valid = 1'b1;
      set_req(2'd0, 1'b0, 32'hFFFF_FFFC, 26'h0, 32'h0);
      cycle(acc);
      in_valid = 1'b0;
      cycle(acc);
      chk("seq_wrap", out_target, 32'h0);
      cycle(acc);

      base = n_pop;
      for (int i = 0; i < 10; i++) begin
         in_valid = i < 8;
         set_rand();
         cycle(acc);
         if (i < 8) chk("b2b_accept", acc, 1'b1);
      end
      chk("b2b_pops", n_pop - base, 8);

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) pcs[i] = $urandom & 32'hFFFF_FFFC;
      k = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = k < 3;
         set_req(2'd0, 1'b0, pcs[k < 3 ? k : 2], 26'h0, 32'h0);
         cycle(acc);
         if (acc) k++;
      end
      chk("stall_accepted", k, 2);
      chk("stall_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      base = n_pop;
      for (int i = 0; i < 8; i++) begin
         in_valid = k < 3;
         set_req(2'd0, 1'b0, pcs[k < 3 ? k : 2], 26'h0, 32'h0);
         cycle(acc);
         if (acc) k++;
      end
      chk("stall_release_pops", n_pop - base, 3);

      out_ready = 1'b0;
      in_valid = 1'b1;
      set_rand(); cycle(acc);
      set_rand(); cycle(acc);
      chk("flush_full", out_valid, 1'b1);
      flush = 1'b1;
      set_rand(); cycle(acc);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle(acc);

`ifdef JTG_MISALIGN_CHECK_EN
      in_valid = 1'b1;
      set_req(2'd3, 1'b0, 32'h0, 26'h0, 32'h0040_0002);
      cycle(acc);
      in_valid = 1'b0;
      cycle(acc);
      chk("misalign_target", out_target, 32'h0040_0002);
      chk("misalign_flag", out_misalign, 1'b1);
      cycle(acc);
`endif

      for (int i = 0; i < 600; i++) begin
         in_valid  = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 7;
         flush     = $urandom_range(0, 99) < 3;
         set_rand();
         cycle(acc);
      end
      flush = 1'b0;

      out_ready = 1'b0;
      in_valid = 1'b1;
      set_rand(); cycle(acc);
      set_rand(); cycle(acc);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_target", out_target, 32'h0);
      chk("async_rst_ready", in_ready, 1'b1);
      q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         in_valid  = $urandom_range(0, 9) < 8;
         out_ready = $urandom_range(0, 9) < 5;
         set_rand();
         cycle(acc);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle(acc);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
